// File: rtl/jala_stack_pkg.sv
// rtl/jala_stack_pkg.sv - op/transfer encodings and error bit indices for the dual stack
package jala_stack_pkg;

    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11
    } stackOpE;

    typedef enum logic [1:0] {
        XFER_NONE = 2'b00,
        XFER_M2R  = 2'b01,
        XFER_R2M  = 2'b10,
        XFER_RSVD = 2'b11
    } xferE;

    localparam int ERR_M_OVF = 0;
    localparam int ERR_M_UDF = 1;
    localparam int ERR_R_OVF = 2;
    localparam int ERR_R_UDF = 3;

endpackage

// File: rtl/stack_channel.sv
// rtl/stack_channel.sv - single LIFO with push/pop/replace/clear and overflow/underflow pulses
module stack_channel #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       replace,
    input  logic [DATA_W-1:0]          wrData,
    output logic [DATA_W-1:0]          top,
    output logic [DATA_W-1:0]          next,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_TWO  = CW'(2);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wrIdx;
    logic [AW-1:0]     topIdx;
    logic [AW-1:0]     nextIdx;
    logic              doPush;
    logic              doPop;
    logic              doReplace;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign wrIdx   = AW'(count);
    assign topIdx  = AW'(count - CNT_ONE);
    assign nextIdx = AW'(count - CNT_TWO);

    // clear outranks every op and swallows its error pulse as well
    assign doPush    = !clr && push && !full;
    assign doPop     = !clr && !push && pop && !empty;
    assign doReplace = !clr && !push && !pop && replace && !empty;
    assign overflow  = !clr && push && full;
    assign underflow = !clr && !push && (pop || replace) && empty;

    assign top  = empty ? '0 : mem[topIdx];
    assign next = (count >= CNT_TWO) ? mem[nextIdx] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (doPush) begin
            count <= count + CNT_ONE;
        end else if (doPop) begin
            count <= count - CNT_ONE;
        end
    end

    // storage is deliberately unreset; outputs are masked by count instead
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrIdx] <= wrData;
        end else if (doReplace) begin
            mem[topIdx] <= wrData;
        end
    end

endmodule

// File: rtl/dual_stack_unit.sv
// rtl/dual_stack_unit.sv - main/return stack pair with atomic transfer and sticky errors
module dual_stack_unit
    import jala_stack_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int M_DEPTH = 16,
    parameter int R_DEPTH = 16
) (
    input  logic                        CLK,
    input  logic                        CtrlRst,
    input  logic [1:0]                  MOp,
    input  logic [DATA_W-1:0]           MData,
    input  logic [1:0]                  ROp,
    input  logic [DATA_W-1:0]           RData,
    input  logic [1:0]                  Xfer,
    input  logic                        MClr,
    input  logic                        RClr,
    input  logic                        ErrClr,
    output logic [DATA_W-1:0]           MTop,
    output logic [DATA_W-1:0]           MNext,
    output logic [DATA_W-1:0]           RTop,
    output logic [$clog2(M_DEPTH):0]    MSPOut,
    output logic [$clog2(R_DEPTH):0]    RSPOut,
    output logic                        MFull,
    output logic                        MEmpty,
    output logic                        RFull,
    output logic                        REmpty,
    output logic [3:0]                  Err
);
    logic              mPush, mPop, mReplace, mOvf, mUdf;
    logic              rPush, rPop, rReplace, rOvf, rUdf;
    logic [DATA_W-1:0] mWr, rWr;
    logic [DATA_W-1:0] rNextUnused;
    logic [3:0]        xferErr;
    logic [3:0]        raised;

    always_comb begin
        mPush    = 1'b0;
        mPop     = 1'b0;
        mReplace = 1'b0;
        rPush    = 1'b0;
        rPop     = 1'b0;
        rReplace = 1'b0;
        mWr      = MData;
        rWr      = RData;
        xferErr  = '0;
        if (Xfer == XFER_M2R || Xfer == XFER_R2M) begin
            // a clear on either side cancels the transfer outright, without error
            if (!MClr && !RClr) begin
                if (Xfer == XFER_M2R) begin
                    xferErr[ERR_M_UDF] = MEmpty;
                    xferErr[ERR_R_OVF] = RFull;
                    if (!MEmpty && !RFull) begin
                        mPop  = 1'b1;
                        rPush = 1'b1;
                        rWr   = MTop;
                    end
                end else begin
                    xferErr[ERR_R_UDF] = REmpty;
                    xferErr[ERR_M_OVF] = MFull;
                    if (!REmpty && !MFull) begin
                        rPop  = 1'b1;
                        mPush = 1'b1;
                        mWr   = RTop;
                    end
                end
            end
        end else begin
            mPush    = (MOp == OP_PUSH);
            mPop     = (MOp == OP_POP);
            mReplace = (MOp == OP_REPLACE);
            rPush    = (ROp == OP_PUSH);
            rPop     = (ROp == OP_POP);
            rReplace = (ROp == OP_REPLACE);
        end
    end

    stack_channel #(.DATA_W(DATA_W), .DEPTH(M_DEPTH)) uMain (
        .clk(CLK), .rst(CtrlRst), .clr(MClr),
        .push(mPush), .pop(mPop), .replace(mReplace), .wrData(mWr),
        .top(MTop), .next(MNext), .count(MSPOut),
        .full(MFull), .empty(MEmpty), .overflow(mOvf), .underflow(mUdf)
    );

    stack_channel #(.DATA_W(DATA_W), .DEPTH(R_DEPTH)) uRet (
        .clk(CLK), .rst(CtrlRst), .clr(RClr),
        .push(rPush), .pop(rPop), .replace(rReplace), .wrData(rWr),
        .top(RTop), .next(rNextUnused), .count(RSPOut),
        .full(RFull), .empty(REmpty), .overflow(rOvf), .underflow(rUdf)
    );

    always_comb begin
        raised            = xferErr;
        raised[ERR_M_OVF] = raised[ERR_M_OVF] | mOvf;
        raised[ERR_M_UDF] = raised[ERR_M_UDF] | mUdf;
        raised[ERR_R_OVF] = raised[ERR_R_OVF] | rOvf;
        raised[ERR_R_UDF] = raised[ERR_R_UDF] | rUdf;
    end

    // same-cycle errors survive ErrClr
    always_ff @(posedge CLK or posedge CtrlRst) begin
        if (CtrlRst) begin
            Err <= '0;
        end else begin
            Err <= (ErrClr ? 4'h0 : Err) | raised;
        end
    end

    logic unusedOk;
    assign unusedOk = ^rNextUnused;

endmodule

// File: tb/tb_dual_stack_unit.sv
// tb/tb_dual_stack_unit.sv - randomized self-checking bench against a queue-based stack model
module tb_dual_stack_unit;
    localparam int MD = 16;
    localparam int RD = 16;

    logic        CLK;
    logic        CtrlRst;
    logic [1:0]  MOp, ROp, Xfer;
    logic [15:0] MData, RData;
    logic        MClr, RClr, ErrClr;
    logic [15:0] MTop, MNext, RTop;
    logic [4:0]  MSPOut, RSPOut;
    logic        MFull, MEmpty, RFull, REmpty;
    logic [3:0]  Err;

    dual_stack_unit #(.DATA_W(16), .M_DEPTH(MD), .R_DEPTH(RD)) dut (
        .CLK(CLK), .CtrlRst(CtrlRst), .MOp(MOp), .MData(MData), .ROp(ROp), .RData(RData),
        .Xfer(Xfer), .MClr(MClr), .RClr(RClr), .ErrClr(ErrClr),
        .MTop(MTop), .MNext(MNext), .RTop(RTop), .MSPOut(MSPOut), .RSPOut(RSPOut),
        .MFull(MFull), .MEmpty(MEmpty), .RFull(RFull), .REmpty(REmpty), .Err(Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          nTests = 0;
    int          nFail  = 0;
    logic [15:0] mq[$];
    logic [15:0] rq[$];
    logic [3:0]  errM;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkAll();
        checkVal("msp", 32'(MSPOut), mq.size());
        checkVal("rsp", 32'(RSPOut), rq.size());
        checkVal("mtop", 32'(MTop), (mq.size() > 0) ? 32'(mq[mq.size()-1]) : 0);
        checkVal("mnext", 32'(MNext), (mq.size() > 1) ? 32'(mq[mq.size()-2]) : 0);
        checkVal("rtop", 32'(RTop), (rq.size() > 0) ? 32'(rq[rq.size()-1]) : 0);
        checkVal("mfull", 32'(MFull), 32'(mq.size() == MD));
        checkVal("mempty", 32'(MEmpty), 32'(mq.size() == 0));
        checkVal("rfull", 32'(RFull), 32'(rq.size() == RD));
        checkVal("rempty", 32'(REmpty), 32'(rq.size() == 0));
        checkVal("err", 32'(Err), 32'(errM));
    endtask

    task automatic modelStep(input logic [1:0] mop, input logic [15:0] md, input logic [1:0] rop,
                             input logic [15:0] rd, input logic [1:0] xf, input logic mc,
                             input logic rc, input logic ec);
        logic [3:0]  raised;
        logic [15:0] v;
        raised = '0;
        if (xf == 2'b01 || xf == 2'b10) begin
            if (mc) mq.delete();
            if (rc) rq.delete();
            if (!mc && !rc) begin
                if (xf == 2'b01) begin
                    if (mq.size() == 0) raised[1] = 1'b1;
                    if (rq.size() == RD) raised[2] = 1'b1;
                    if (raised == 0) begin v = mq.pop_back(); rq.push_back(v); end
                end else begin
                    if (rq.size() == 0) raised[3] = 1'b1;
                    if (mq.size() == MD) raised[0] = 1'b1;
                    if (raised == 0) begin v = rq.pop_back(); mq.push_back(v); end
                end
            end
        end else begin
            if (mc) mq.delete();
            else if (mop == 2'b01) begin
                if (mq.size() == MD) raised[0] = 1'b1; else mq.push_back(md);
            end else if (mop == 2'b10) begin
                if (mq.size() == 0) raised[1] = 1'b1; else v = mq.pop_back();
            end else if (mop == 2'b11) begin
                if (mq.size() == 0) raised[1] = 1'b1; else mq[mq.size()-1] = md;
            end
            if (rc) rq.delete();
            else if (rop == 2'b01) begin
                if (rq.size() == RD) raised[2] = 1'b1; else rq.push_back(rd);
            end else if (rop == 2'b10) begin
                if (rq.size() == 0) raised[3] = 1'b1; else v = rq.pop_back();
            end else if (rop == 2'b11) begin
                if (rq.size() == 0) raised[3] = 1'b1; else rq[rq.size()-1] = rd;
            end
        end
        errM = (ec ? 4'h0 : errM) | raised;
    endtask

    task automatic drive(input logic [1:0] mop, input logic [15:0] md, input logic [1:0] rop,
                         input logic [15:0] rd, input logic [1:0] xf, input logic mc,
                         input logic rc, input logic ec);
        MOp = mop; MData = md; ROp = rop; RData = rd; Xfer = xf;
        MClr = mc; RClr = rc; ErrClr = ec;
        modelStep(mop, md, rop, rd, xf, mc, rc, ec);
        @(posedge CLK);
        #1;
        checkAll();
    endtask

    task automatic idle();
        drive(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        CtrlRst = 1'b0;
        MOp = 0; ROp = 0; Xfer = 0; MData = 0; RData = 0;
        MClr = 0; RClr = 0; ErrClr = 0;
        errM = '0;
        #1 CtrlRst = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checkVal("rst_msp", 32'(MSPOut), 0);
        checkVal("rst_rsp", 32'(RSPOut), 0);
        checkVal("rst_mempty", 32'(MEmpty), 1);
        checkVal("rst_rempty", 32'(REmpty), 1);
        checkVal("rst_mtop", 32'(MTop), 0);
        checkVal("rst_err", 32'(Err), 0);
        CtrlRst = 1'b0;

        drive(2'b01, 16'h1111, 2'b00, 16'h0, 2'b00, 0, 0, 0);
        drive(2'b01, 16'h2222, 2'b00, 16'h0, 2'b00, 0, 0, 0);
        drive(2'b01, 16'h3333, 2'b00, 16'h0, 2'b00, 0, 0, 0);
        checkVal("push3_msp", 32'(MSPOut), 3);
        checkVal("push3_mtop", 32'(MTop), 32'h3333);
        checkVal("push3_mnext", 32'(MNext), 32'h2222);
        checkVal("push3_err", 32'(Err), 0);

        for (int i = 3; i < MD; i++) drive(2'b01, 16'(16'h4000 + i), 2'b00, 16'h0, 2'b00, 0, 0, 0);
        drive(2'b01, 16'hBEEF, 2'b00, 16'h0, 2'b00, 0, 0, 0);
        checkVal("ovf_msp", 32'(MSPOut), 16);
        checkVal("ovf_mfull", 32'(MFull), 1);
        checkVal("ovf_err0", 32'(Err[0]), 1);
        checkVal("ovf_mtop", 32'(MTop), 32'h400F);

        drive(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 0, 0, 1);
        drive(2'b00, 16'h0, 2'b10, 16'h0, 2'b00, 0, 0, 0);
        checkVal("rudf_rsp", 32'(RSPOut), 0);
        checkVal("rudf_err3", 32'(Err[3]), 1);
        drive(2'b00, 16'h0, 2'b10, 16'h0, 2'b00, 0, 0, 1);
        checkVal("errclr_same", 32'(Err[3]), 1);
        drive(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 0, 0, 1);
        checkVal("errclr_alone", 32'(Err), 0);

        drive(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1, 1, 0);
        drive(2'b01, 16'hA5A5, 2'b00, 16'h0, 2'b00, 0, 0, 0);
        drive(2'b01, 16'h0001, 2'b00, 16'h0, 2'b01, 0, 0, 0);
        checkVal("xfer_msp", 32'(MSPOut), 0);
        checkVal("xfer_rsp", 32'(RSPOut), 1);
        checkVal("xfer_rtop", 32'(RTop), 32'hA5A5);

        for (int i = 0; i < 5; i++) drive(2'b01, 16'(16'h5000 + i), 2'b00, 16'h0, 2'b00, 0, 0, 0);
        drive(2'b00, 16'h0, 2'b00, 16'h0, 2'b01, 1, 0, 0);
        checkVal("clrxfer_msp", 32'(MSPOut), 0);
        checkVal("clrxfer_rsp", 32'(RSPOut), 1);
        checkVal("clrxfer_err", 32'(Err), 0);

        for (int i = 0; i < 800; i++) begin
            logic [1:0] mop, rop, xf;
            int pushBias;
            pushBias = (i < 400) ? 6 : 3;
            mop = ($urandom_range(0, 9) < pushBias) ? 2'b01 : 2'($urandom_range(0, 3));
            rop = ($urandom_range(0, 9) < pushBias) ? 2'b01 : 2'($urandom_range(0, 3));
            xf  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            drive(mop, 16'($urandom), rop, 16'($urandom), xf,
                  $urandom_range(0, 40) == 0, $urandom_range(0, 40) == 0,
                  $urandom_range(0, 7) == 0);
        end

        for (int i = 0; i < 4; i++) drive(2'b01, 16'($urandom), 2'b01, 16'($urandom), 2'b00, 0, 0, 0);
        #2 CtrlRst = 1'b1;
        #1;
        checkVal("arst_msp", 32'(MSPOut), 0);
        checkVal("arst_rsp", 32'(RSPOut), 0);
        checkVal("arst_mempty", 32'(MEmpty), 1);
        checkVal("arst_rempty", 32'(REmpty), 1);
        checkVal("arst_mtop", 32'(MTop), 0);
        checkVal("arst_rtop", 32'(RTop), 0);
        checkVal("arst_err", 32'(Err), 0);
        mq.delete();
        rq.delete();
        errM = '0;
        #2 CtrlRst = 1'b0;
        idle();
        drive(2'b01, 16'h7777, 2'b01, 16'h8888, 2'b00, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/dual_stack_unit.md
DUAL_STACK_UNIT -- requirements
Module: dual_stack_unit

Interface
REQ-001 Parameter DATA_W, default 16: data width of every stack entry.
REQ-002 Parameter M_DEPTH, default 16: main-stack capacity in entries, minimum 2.
REQ-003 Parameter R_DEPTH, default 16: return-stack capacity in entries, minimum 2.
REQ-004 Ports: CLK  in  1  sole clock; all state updates on the rising edge.
REQ-005 Ports: CtrlRst  in  1  reset, asynchronous, active-high.
REQ-006 Ports: MOp  in  2  main op: 00 none, 01 push, 10 pop, 11 replace-top.
REQ-007 Ports: MData  in  DATA_W  main push/replace data.
REQ-008 Ports: ROp  in  2  return op, same encoding as MOp.
REQ-009 Ports: RData  in  DATA_W  return push/replace data.
REQ-010 Ports: Xfer  in  2  transfer: 00 none, 01 main->return, 10 return->main, 11 treated as 00.
REQ-011 Ports: MClr, RClr  in  1 each  synchronous per-channel clear.
REQ-012 Ports: ErrClr  in  1  synchronous clear of sticky error flags.
REQ-013 Ports: MTop, MNext, RTop  out  DATA_W  main top, main second entry, return top.
REQ-014 Ports: MSPOut  out  clog2(M_DEPTH)+1; RSPOut  out  clog2(R_DEPTH)+1  entry counts.
REQ-015 Ports: MFull, MEmpty, RFull, REmpty  out  1 each  occupancy flags.
REQ-016 Ports: Err  out  4  sticky: [0] main overflow, [1] main underflow, [2] return overflow, [3] return underflow.

Function
REQ-017 Each count SHALL range 0..DEPTH; Full = (count == DEPTH), Empty = (count == 0).
REQ-018 Push SHALL write the data at index count and increment count; it is visible on Top after the same rising edge (1-cycle latency).
REQ-019 Pop SHALL decrement count; popped contents are not cleared.
REQ-020 Replace SHALL overwrite the top entry and leave count unchanged.
REQ-021 Top outputs SHALL be combinational from registered state: entry[count-1] when count >= 1, otherwise 0; MNext = entry[count-2] when count >= 2, otherwise 0.
REQ-022 A push on a full channel SHALL leave that channel unchanged and set its overflow bit.
REQ-023 A pop or replace on an empty channel SHALL leave that channel unchanged and set its underflow bit.
REQ-024 When Xfer is nonzero, MOp and ROp SHALL be ignored in that cycle.
REQ-025 Xfer 01 SHALL pop main and push the popped value onto return atomically in one cycle; 10 SHALL do the reverse.
REQ-026 Xfer SHALL change neither stack when the source is empty (set source underflow) or the destination is full (set destination overflow); both conditions may flag together.
REQ-027 MClr/RClr SHALL set that channel's count to 0 and SHALL take priority over the channel's op and over any Xfer touching that channel; a blocked Xfer changes neither stack and sets no error.
REQ-028 Priority per channel: Clr > Xfer > op.
REQ-029 ErrClr SHALL zero Err, except that an error raised in the same cycle SHALL remain set.
REQ-030 Main and return channels SHALL operate independently in the same cycle when Xfer is 00.

Reset
REQ-031 CtrlRst SHALL asynchronously force both counts to 0 and Err to 0; while asserted, all outputs read 0 except MEmpty = REmpty = 1.
REQ-032 Storage arrays SHALL NOT be reset; Top and Next outputs are masked to 0 by count.
REQ-033 A CtrlRst assertion mid-transfer SHALL leave no partial update; both stacks read empty.

Structure
REQ-034 Shared package jala_stack_pkg SHALL hold the op encodings, the Xfer encodings and the Err bit indices.
REQ-035 Sub-module stack_channel (parameters DATA_W, DEPTH; a single LIFO with push/pop/replace/clear, overflow/underflow pulses) SHALL be instantiated twice; the top level arbitrates Xfer and holds Err.

Verification
REQ-036 Reset, then main push 0x1111, 0x2222, 0x3333 -> MSPOut=3, MTop=0x3333, MNext=0x2222, Err=0.
REQ-037 Fill main to 16 entries, then push 0xBEEF -> MSPOut stays 16, MFull=1, Err[0]=1, MTop unchanged.
REQ-038 Empty return stack, ROp=pop -> RSPOut=0, Err[3]=1; assert ErrClr together with another pop -> Err[3] stays 1; next cycle ErrClr alone -> Err=0.
REQ-039 Main holds 0xA5A5, return empty, Xfer=01 with MOp=push 0x0001 -> MSPOut=0, RSPOut=1, RTop=0xA5A5, MOp ignored.
REQ-040 Main holds 5 entries, MClr together with Xfer=01 -> MSPOut=0, RSPOut unchanged, Err=0.
REQ-041 Assert CtrlRst asynchronously between clock edges with both stacks loaded -> counts read 0 immediately, MEmpty=REmpty=1, MTop=RTop=0.
